printf_buffer_fetch: RTL
========================

Name: printf_buffer_fetch

Overview:
- Synthesizable bare-metal printf engine that sits directly upstream of the system-level log sink.
- When a core posts a printf buffer address, the block fetches the buffer from scratchpad (main) memory 64 bits at a time and zero-clears each word after reading it.
- It left-justifies the text by stopping at the first NUL/LF/CR and streams the characters, tagged with the issuing core ID, to the log/console consumer.
- It replaces the simulation-only backdoor fetch with a real memory-port master.

Parameters:
- NUM_WORDS, 16, 64-bit words per printf buffer (buffer bytes = 8*NUM_WORDS, max 128).
- LEN_W, 8, width of the character-count output; must hold 8*NUM_WORDS.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  printf request.
- cmd_ready  out  1  request accepted when cmd_valid & cmd_ready.
- cmd_addr  in  32  buffer address; [31:3] is the word base, [1:0] is the core ID.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (clear), 0 = read.
- mem_addr  out  32  byte address, 8-byte aligned.
- mem_wdata  out  64  write data, always 0.
- mem_mask  out  8  byte enables, always 8'hFF.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  64  read data.
- chr_valid  out  1  character beat valid.
- chr_ready  in  1  consumer accepts beat.
- chr_data  out  8  character; 8'h00 on the end marker.
- chr_last  out  1  end-of-message marker beat.
- chr_core  out  2  core ID of the current message.
- busy  out  1  message in progress.
- done  out  1  one-cycle pulse after the end marker is accepted.
- msg_len  out  LEN_W  characters emitted, excluding the marker; valid when done=1 and held until the next accept.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State returns to IDLE, including mid-transaction; any outstanding memory read is abandoned.
  - All outputs go to 0 except cmd_ready=1. mem_wdata=0 and mem_mask=8'hFF are constants.
- State machine: IDLE, RD_REQ, RD_WAIT, CLR, EMIT, FLUSH, EOM.
- IDLE:
  - cmd_ready=1.
  - On accept: latch base={cmd_addr[31:3],3'b0} and core=cmd_addr[1:0]; clear word index w, byte index b, length counter and the term flag; go to RD_REQ next cycle.
  - cmd_ready=0 in all other states.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_addr=base+8*w.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
  - Hold the request until mem_gnt, then go to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid, capture mem_rdata in the word register; go to CLR.
  - Only one read is outstanding at a time. mem_rvalid in any other state is ignored.
- CLR:
  - mem_req=1, mem_we=1, same address, data 0; hold until mem_gnt.
  - Then: if term=0 go to EMIT with b=0; if term=1 go to FLUSH.
- EMIT:
  - The current byte is word[63-8b -: 8]; the MS byte is the first character.
  - If the byte is 8'h00, 8'h0A or 8'h0D: set term=1; nothing is emitted; move on as if the word were exhausted.
  - Otherwise drive chr_valid=1, chr_data=byte, chr_last=0. Hold until chr_ready, then increment length and b.
  - Word exhausted (b==7 accepted, or terminator found):
    - if w==NUM_WORDS-1 go to EOM;
    - else increment w and go to RD_REQ when term=0, or FLUSH when term=1.
- FLUSH:
  - Clears the remaining words without emitting anything.
  - Per word: the read is still performed (RD_REQ/RD_WAIT, data discarded), then CLR.
  - After the last word, go to EOM.
  - Net effect: every word of the buffer is zero after each message.
- EOM:
  - chr_valid=1, chr_last=1, chr_data=0.
  - On chr_ready: done=1 for one cycle, msg_len=count, return to IDLE.
- Output stability: chr_data and chr_core are stable while chr_valid=1 and chr_ready=0. mem_addr and mem_we are stable while mem_req=1 and mem_gnt=0.
- Boundary cases:
  - 128 non-terminator bytes: msg_len=128, no FLUSH.
  - Terminator in byte 0 of word 0: msg_len=0; EOM is still emitted.
  - mem_gnt and chr_ready asserted constantly: one character per cycle within a word.
- Latency: with single-cycle gnt and rvalid, the first character is valid at most 5 cycles after cmd accept.

Test Plan:
- Buffer "Hi\n" (word0=64'h48690A0000000000, rest 0), cmd_addr=32'h8000_1002 -> chars 'H','i' then marker; chr_core=2; msg_len=2; 16 reads and 16 zero writes at 32'h8000_1000..32'h8000_1078; memory all 0 afterwards.
- 128 bytes of 8'h41, no terminator -> 128 beats of 'A' plus marker; msg_len=128; last read address base+0x78.
- word0 = 64'h00... -> only the marker beat; msg_len=0; all 16 words still read and cleared.
- chr_ready toggling 1/0 every cycle, mem_gnt delayed 3 cycles, rvalid delayed 2 cycles -> identical character sequence; outputs stable while stalled; no duplicated or dropped beats.
- rst_n pulled low mid-EMIT on the 5th character -> all outputs 0 and cmd_ready=1 immediately (async); a new command afterwards completes normally with the correct msg_len.
- Back-to-back commands (cmd_valid held) -> second accepted only on the cycle after done; a CR (8'h0D) terminator in byte 3 of word 1 gives msg_len=11.

Source files
------------

// File: rtl/printf_buffer_fetch.sv
// ---------------------------------------------------------------------------
// printf_buffer_fetch
//
// Bare-metal printf engine. A core posts the address of its printf buffer;
// the block walks the buffer one 64-bit word at a time over a simple
// request/grant memory port. For each word it performs:
//   1. a read
//   2. a zero write that clears the word
//   3. the streaming of the word's characters, most-significant byte first,
//      to the log consumer
// The first NUL, LF or CR ends the text. The words after that point are still
// read and cleared, so the whole buffer is zero when the message ends. Every
// message finishes with an end-marker beat (chr_last=1, chr_data=0).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   request handshake
//   cmd_addr          [31:3] is the word base of the buffer, [1:0] is the core ID
//   mem_req/we/addr   memory master: request, write enable, byte address
//   mem_wdata/mask    write data (always 0) and byte enables (always all ones)
//   mem_gnt           request accepted
//   mem_rvalid/rdata  read data return
//   chr_valid/ready   character stream handshake
//   chr_data          character byte (0 on the end marker)
//   chr_last          end-of-message marker
//   chr_core          core ID of the message being streamed
//   busy              a message is in progress
//   done              one-cycle pulse after the end marker is accepted
//   msg_len           number of characters in the last message
// ---------------------------------------------------------------------------
module printf_buffer_fetch #(
    parameter int NUM_WORDS = 16,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    output logic [7:0]       mem_mask,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [63:0]      mem_rdata,
    output logic             chr_valid,
    input  logic             chr_ready,
    output logic [7:0]       chr_data,
    output logic             chr_last,
    output logic [1:0]       chr_core,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] msg_len
);

    localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CLR,
        EMIT,
        FLUSH,
        EOM
    } state_t;

    state_t            state_q;
    logic [31:0]       baseAddr_q;
    logic [1:0]        coreId_q;
    logic [WORD_W-1:0] wordIdx_q;
    logic [2:0]        byteIdx_q;
    logic [LEN_W-1:0]  charCount_q;
    logic [LEN_W-1:0]  msgLen_q;
    logic              term_q;
    logic              done_q;
    logic [63:0]       word_q;

    logic [7:0]        curByte;
    logic              curIsTerm;
    logic [31:0]       wordOffset;
    logic              lastWord;
    logic              unused_cmdAddrBit2;

    // Bit 2 of the command address lies inside the 8-byte word and is not
    // part of either the word base or the core ID.
    assign unused_cmdAddrBit2 = cmd_addr[2];

    // Byte 0 is the MS byte. ~byteIdx_q equals 7 - byteIdx_q.
    assign curByte    = word_q[{~byteIdx_q, 3'b000} +: 8];
    assign curIsTerm  = (curByte == 8'h00) || (curByte == 8'h0A) || (curByte == 8'h0D);
    assign wordOffset = {{(29 - WORD_W){1'b0}}, wordIdx_q, 3'b000};
    assign lastWord   = (wordIdx_q == LAST_WORD);

    // All outputs are decoded only from registered state. Because no input
    // reaches an output, every output holds steady during a stall.
    // cmd_ready stays low during the done pulse. A command that is held
    // across messages is therefore accepted on the cycle after done.
    assign cmd_ready = (state_q == IDLE) && !done_q;
    assign mem_req   = (state_q == RD_REQ) || (state_q == CLR);
    assign mem_we    = (state_q == CLR);
    assign mem_addr  = mem_req ? (baseAddr_q + wordOffset) : 32'h0;
    assign mem_wdata = 64'h0;
    assign mem_mask  = 8'hFF;
    assign chr_valid = ((state_q == EMIT) && !curIsTerm) || (state_q == EOM);
    assign chr_data  = ((state_q == EMIT) && !curIsTerm) ? curByte : 8'h00;
    assign chr_last  = (state_q == EOM);
    assign chr_core  = coreId_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign msg_len   = msgLen_q;

    // Main sequencer. A word is always read, then cleared, then streamed
    // unless a terminator has already been seen. FLUSH advances to the next
    // word, or ends the message after the last word. When EMIT finds a
    // terminator it leaves the word advance to FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baseAddr_q  <= 32'h0;
            coreId_q    <= 2'b00;
            wordIdx_q   <= '0;
            byteIdx_q   <= 3'd0;
            charCount_q <= '0;
            msgLen_q    <= '0;
            term_q      <= 1'b0;
            done_q      <= 1'b0;
            word_q      <= 64'h0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        baseAddr_q  <= {cmd_addr[31:3], 3'b000};
                        coreId_q    <= cmd_addr[1:0];
                        wordIdx_q   <= '0;
                        byteIdx_q   <= 3'd0;
                        charCount_q <= '0;
                        term_q      <= 1'b0;
                        state_q     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        // Once the message has ended, the read data is not needed.
                        if (!term_q) begin
                            word_q <= mem_rdata;
                        end
                        state_q <= CLR;
                    end
                end
                CLR: begin
                    if (mem_gnt) begin
                        byteIdx_q <= 3'd0;
                        state_q   <= term_q ? FLUSH : EMIT;
                    end
                end
                EMIT: begin
                    if (curIsTerm) begin
                        term_q  <= 1'b1;
                        state_q <= lastWord ? EOM : FLUSH;
                    end else if (chr_ready) begin
                        charCount_q <= charCount_q + LEN_W'(1);
                        if (byteIdx_q == 3'd7) begin
                            if (lastWord) begin
                                state_q <= EOM;
                            end else begin
                                wordIdx_q <= wordIdx_q + WORD_W'(1);
                                state_q   <= RD_REQ;
                            end
                        end else begin
                            byteIdx_q <= byteIdx_q + 3'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (lastWord) begin
                        state_q <= EOM;
                    end else begin
                        wordIdx_q <= wordIdx_q + WORD_W'(1);
                        state_q   <= RD_REQ;
                    end
                end
                EOM: begin
                    if (chr_ready) begin
                        done_q   <= 1'b1;
                        msgLen_q <= charCount_q;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
